lut_loader: RTL

Runtime-loadable arctan(2^-i) table for the CORDIC datapath. It is the write-side counterpart of the fixed read-only table. A host or boot sequencer streams N_ITERATIONS angle words in over a valid/ready handshake. The block stores them in order, reports when the table is complete, and serves the same combinational read port the CORDIC iteration stage already uses.

---
 rtl/cordic_pkg.sv | 15 +
 rtl/lut_ram.sv | 30 +++
 rtl/lut_loader.sv | 103 ++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: table geometry defaults and the loader state type.
package cordic_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int N_ITERATIONS = 15;
    localparam int ADDR_W       = $clog2(N_ITERATIONS);
    localparam int CNT_W        = $clog2(N_ITERATIONS + 1);

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        LOADED
    } lut_state_t;

endpackage

// File: rtl/lut_ram.sv
// Arctangent table storage: one synchronous write port and one asynchronous
// read port. It is the writable stand-in for the fixed ROM table.
module lut_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 15,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store a word on the edge where the loader accepts it; no reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read straight through so the CORDIC stage sees the same zero-latency path as the ROM.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/lut_loader.sv
// Runtime loader for the CORDIC arctangent table. It accepts N_ITERATIONS words
// over valid/ready, stores them in index order and serves a gated
// combinational read port.
module lut_loader #(
    parameter int DATA_WIDTH   = cordic_pkg::DATA_WIDTH,
    parameter int N_ITERATIONS = cordic_pkg::N_ITERATIONS,
    parameter int ADDR_W       = $clog2(N_ITERATIONS),
    parameter int CNT_W        = $clog2(N_ITERATIONS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  loaded,
    output logic                  busy,
    output logic [CNT_W-1:0]      load_count
);

    import cordic_pkg::*;

    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(N_ITERATIONS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ITERATIONS - 1);

    lut_state_t            state_q;
    lut_state_t            state_d;
    logic [ADDR_W-1:0]     wr_ptr;
    logic                  accept;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign accept = wr_valid & wr_ready;

    // State register; reset has priority over everything, including start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start always (re)enters LOADING, and the last accepted word finishes the load.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LOADING;
        end else begin
            case (state_q)
                LOADING: begin
                    if (accept && (load_count == LAST_CNT)) begin
                        state_d = LOADED;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Status outputs; ready drops in a start cycle so a word presented alongside start is never taken.
    always_comb begin
        wr_ready = (state_q == LOADING) && !start;
        busy     = (state_q == LOADING);
        loaded   = (state_q == LOADED);
    end

    // Write pointer and word counter restart on start and advance once per accepted word.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            wr_ptr     <= '0;
            load_count <= '0;
        end else if (accept) begin
            wr_ptr     <= wr_ptr + 1'b1;
            load_count <= load_count + 1'b1;
        end
    end

    lut_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (N_ITERATIONS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // Hide the table (stale or half-written) unless it is complete and the index is in range.
    always_comb begin
        data_out = '0;
        if ((state_q == LOADED) && (raddr <= LAST_ADDR)) begin
            data_out = ram_rdata;
        end
    end

endmodule
